// File: rtl/lsu_thread.sv
// -----------------------------------------------------------------------------
// lsu_thread
//   Per-thread load/store unit. Accepts one LDR or STR per instruction while
//   the core is in its REQUEST phase, drives a valid/ready memory channel until
//   the memory accepts, then parks in DONE until the core reaches WRITEBACK.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   enable              thread active; low freezes every register
//   core_state[2:0]     core phase (REQUEST=011, WAIT=100, WRITEBACK=110)
//   mem_read_enable     decoded LDR
//   mem_write_enable    decoded STR (ignored when LDR is also set)
//   rs, rt              register operands: address and store data
//   mem_read_*          read channel (valid/address out, ready/data in)
//   mem_write_*         write channel (valid/address/data out, ready in)
//   lsu_state[1:0]      IDLE=0, REQUESTING=1, WAITING=2, DONE=3
//   lsu_out             last loaded data, to register-file WriteData
// -----------------------------------------------------------------------------
module lsu_thread #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 mem_read_enable,
   input  logic                 mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out
);

   localparam logic [2:0] CORE_REQUEST   = 3'b011;
   localparam logic [2:0] CORE_WRITEBACK = 3'b110;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUESTING = 2'd1,
      WAITING    = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t                 r_state;
   logic                   r_is_read;
   logic                   r_rd_valid;
   logic [ADDR_BITS-1:0]   r_rd_addr;
   logic                   r_wr_valid;
   logic [ADDR_BITS-1:0]   r_wr_addr;
   logic [DATA_BITS-1:0]   r_wr_data;
   logic [DATA_BITS-1:0]   r_out;

   logic [ADDR_BITS-1:0]   w_addr;
   logic                   w_ready;

   assign w_addr  = ADDR_BITS'(rs);
   // Only the ready of the channel actually in use can complete a request.
   assign w_ready = r_is_read ? mem_read_ready : mem_write_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_is_read  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_addr  <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_out      <= '0;
      end else if (enable) begin
         case (r_state)
            IDLE: begin
               if (core_state == CORE_REQUEST && (mem_read_enable || mem_write_enable)) begin
                  // Operands are captured here and never re-sampled, so the
                  // request stays stable however rs/rt move afterwards.
                  // A simultaneous LDR/STR decode is treated as a load.
                  r_is_read <= mem_read_enable;
                  if (mem_read_enable) begin
                     r_rd_valid <= 1'b1;
                     r_rd_addr  <= w_addr;
                  end else begin
                     r_wr_valid <= 1'b1;
                     r_wr_addr  <= w_addr;
                     r_wr_data  <= rt;
                  end
                  r_state <= REQUESTING;
               end
            end
            REQUESTING: begin
               // Ready is not looked at here; the handshake completes in WAITING.
               r_state <= WAITING;
            end
            WAITING: begin
               if (w_ready) begin
                  if (r_is_read) r_out <= mem_read_data;
                  r_rd_valid <= 1'b0;
                  r_wr_valid <= 1'b0;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (core_state == CORE_WRITEBACK) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_read_valid    = r_rd_valid;
   assign mem_read_address  = r_rd_addr;
   assign mem_write_valid   = r_wr_valid;
   assign mem_write_address = r_wr_addr;
   assign mem_write_data    = r_wr_data;
   assign lsu_state         = r_state;
   assign lsu_out           = r_out;

endmodule

// File: tb/tb_lsu_thread.sv
// -----------------------------------------------------------------------------
// tb_lsu_thread
//   Directed bench for lsu_thread. Each launched transaction pushes the
//   lsu_out value expected at its completion; a negedge monitor pops and
//   compares whenever the DUT moves WAITING -> DONE.
// -----------------------------------------------------------------------------
module tb_lsu_thread;

   localparam logic [2:0] C_REQ  = 3'b011;
   localparam logic [2:0] C_WAIT = 3'b100;
   localparam logic [2:0] C_WB   = 3'b110;
   localparam logic [2:0] C_NONE = 3'b000;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [2:0] core_state;
   logic       rd_en, wr_en;
   logic [7:0] rs, rt;
   logic       rvalid, wvalid, rready, wready;
   logic [7:0] raddr, rdata, waddr, wdata;
   logic [1:0] st;
   logic [7:0] lout;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      logic       is_read;
      logic [7:0] out;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   lsu_thread #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
      .mem_read_enable(rd_en), .mem_write_enable(wr_en), .rs(rs), .rt(rt),
      .mem_read_valid(rvalid), .mem_read_address(raddr), .mem_read_ready(rready),
      .mem_read_data(rdata), .mem_write_valid(wvalid), .mem_write_address(waddr),
      .mem_write_data(wdata), .mem_write_ready(wready), .lsu_state(st),
      .lsu_out(lout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every WAITING->DONE completion pops one entry.
   initial begin
      logic [1:0] prev;
      exp_t e;
      prev = 2'd0;
      forever begin
         @(negedge clk);
         if (prev == 2'd2 && st == 2'd3) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_lsu_out", {24'd0, lout}, {24'd0, e.out});
               check("sb_valids_low", {30'd0, rvalid, wvalid}, 32'd0);
            end
         end
         prev = st;
      end
   end

   task automatic writeback();
      core_state = C_WB;
      tick();
      check("wb_to_idle", {30'd0, st}, 32'd0);
      core_state = C_NONE;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; core_state = C_NONE;
      rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
      rready = 1'b0; wready = 1'b0; rdata = 8'h00;
      tick(); tick();
      check("rst_state",  {30'd0, st}, 32'd0);
      check("rst_valids", {30'd0, rvalid, wvalid}, 32'd0);
      check("rst_addrs",  {16'd0, raddr, waddr}, 32'd0);
      check("rst_wdata",  {24'd0, wdata}, 32'd0);
      check("rst_out",    {24'd0, lout}, 32'd0);
      reset = 1'b0;
      tick();
      check("idle_hold", {30'd0, st}, 32'd0);

      // Read, ready already high
      rs = 8'h12; rd_en = 1'b1; core_state = C_REQ; rready = 1'b1; rdata = 8'hA5;
      sb.push_back('{1'b1, 8'hA5});
      tick();
      check("rd_state_req", {30'd0, st}, 32'd1);
      check("rd_valid_c1",  {31'd0, rvalid}, 32'd1);
      check("rd_addr_c1",   {24'd0, raddr}, 32'h12);
      check("rd_wvalid_c1", {31'd0, wvalid}, 32'd0);
      rs = 8'h99; rd_en = 1'b0; core_state = C_WAIT;
      tick();
      check("rd_state_wait", {30'd0, st}, 32'd2);
      check("rd_valid_c2",   {31'd0, rvalid}, 32'd1);
      check("rd_addr_c2",    {24'd0, raddr}, 32'h12);
      tick();
      check("rd_done", {30'd0, st}, 32'd3);
      check("rd_out",  {24'd0, lout}, 32'hA5);
      // DONE holds without WRITEBACK
      for (int i = 0; i < 4; i++) begin
         tick();
         check("done_hold", {30'd0, st}, 32'd3);
      end
      writeback();

      // Write with 5 cycles of backpressure; read-channel ready is irrelevant
      rs = 8'h40; rt = 8'h7E; wr_en = 1'b1; core_state = C_REQ;
      wready = 1'b0; rready = 1'b1; rdata = 8'h5A;
      sb.push_back('{1'b0, 8'hA5});
      tick();
      check("wr_state_req", {30'd0, st}, 32'd1);
      rs = 8'h01; rt = 8'h02; wr_en = 1'b0; core_state = C_WAIT;
      for (int i = 0; i < 5; i++) begin
         check("wr_valid_hold", {31'd0, wvalid}, 32'd1);
         check("wr_addr_hold",  {24'd0, waddr}, 32'h40);
         check("wr_data_hold",  {24'd0, wdata}, 32'h7E);
         check("wr_rvalid_low", {31'd0, rvalid}, 32'd0);
         tick();
         check("wr_state_wait", {30'd0, st}, 32'd2);
      end
      wready = 1'b1;
      tick();
      check("wr_done",      {30'd0, st}, 32'd3);
      check("wr_out_keep",  {24'd0, lout}, 32'hA5);
      wready = 1'b0;
      writeback();

      // Both enables: read only
      rs = 8'h21; rd_en = 1'b1; wr_en = 1'b1; core_state = C_REQ;
      rready = 1'b1; wready = 1'b1; rdata = 8'h3C;
      sb.push_back('{1'b1, 8'h3C});
      tick();
      check("both_rvalid", {31'd0, rvalid}, 32'd1);
      check("both_wvalid", {31'd0, wvalid}, 32'd0);
      check("both_raddr",  {24'd0, raddr}, 32'h21);
      rd_en = 1'b0; wr_en = 1'b0; core_state = C_WAIT;
      tick();
      check("both_wvalid2", {31'd0, wvalid}, 32'd0);
      tick();
      check("both_done", {30'd0, st}, 32'd3);
      check("both_out",  {24'd0, lout}, 32'h3C);
      wready = 1'b0;
      writeback();

      // Freeze during WAITING with ready pulsed
      rs = 8'h55; rd_en = 1'b1; core_state = C_REQ; rready = 1'b0; rdata = 8'h11;
      sb.push_back('{1'b1, 8'h66});
      tick();
      rd_en = 1'b0; core_state = C_WAIT;
      tick();
      check("frz_wait", {30'd0, st}, 32'd2);
      enable = 1'b0; rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_state",  {30'd0, st}, 32'd2);
         check("frz_rvalid", {31'd0, rvalid}, 32'd1);
         check("frz_out",    {24'd0, lout}, 32'h3C);
      end
      enable = 1'b1; rready = 1'b0; rdata = 8'h66;
      tick();
      check("frz_after", {30'd0, st}, 32'd2);
      rready = 1'b1;
      tick();
      check("frz_done", {30'd0, st}, 32'd3);
      check("frz_out2", {24'd0, lout}, 32'h66);
      rready = 1'b0;
      writeback();

      // Reset in WAITING aborts the transaction
      rs = 8'h77; rd_en = 1'b1; core_state = C_REQ;
      tick();
      rd_en = 1'b0; core_state = C_WAIT;
      tick();
      check("abort_wait", {30'd0, st}, 32'd2);
      reset = 1'b1;
      tick();
      check("abort_state", {30'd0, st}, 32'd0);
      check("abort_valid", {30'd0, rvalid, wvalid}, 32'd0);
      check("abort_raddr", {24'd0, raddr}, 32'd0);
      check("abort_out",   {24'd0, lout}, 32'd0);
      reset = 1'b0;
      tick(); tick();

      check("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
